// File: rtl/minbd_pkg.sv
// Shared MinBD definitions: flit type, side-buffer defaults and redirect FSM states.
// No logic; latency and backpressure are defined by the modules that import it.
package minbd_pkg;

  localparam int FLIT_W_DEF   = 64;
  localparam int DEPTH_DEF    = 4;
  localparam int REDIR_TH_DEF = 8;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } redir_state_t;

endpackage

// File: rtl/side_buffer_if.sv
// Capture/reinjection bundle between the router and its side buffer.
// Capture side has no ready (losses flag ovf_err); reinjection is valid/ready.
interface side_buffer_if #(
  parameter int FLIT_W = minbd_pkg::FLIT_W_DEF
);

  logic              cap_vld;
  logic [FLIT_W-1:0] cap_flit;
  logic              reinj_ready;
  logic              reinj_vld;
  logic [FLIT_W-1:0] reinj_flit;
  logic              buf_full;
  logic              redir_req;
  logic              ovf_err;

  modport master (
    output cap_vld, cap_flit, reinj_ready,
    input  reinj_vld, reinj_flit, buf_full, redir_req, ovf_err
  );

  modport slave (
    input  cap_vld, cap_flit, reinj_ready,
    output reinj_vld, reinj_flit, buf_full, redir_req, ovf_err
  );

endinterface

// File: rtl/side_buffer_fifo.sv
// sb_fifo: circular store for deflected flits; write-to-read latency 1 cycle.
// A push into a full store succeeds only when a pop happens in the same cycle, else it is dropped.
module sb_fifo #(
  parameter int FLIT_W = minbd_pkg::FLIT_W_DEF,
  parameter int DEPTH  = minbd_pkg::DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic [FLIT_W-1:0] wr_dat,
  input  logic              rd_rdy,
  output logic              rd_vld,
  output logic [FLIT_W-1:0] rd_dat,
  output logic              full,
  output logic              pop,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;

  assign rd_vld = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign pop    = rd_vld & rd_rdy;
  assign push   = wr_vld & (~full | pop);
  assign drop   = wr_vld & full & ~pop;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not cleared; the write is gated so a capture during reset is ignored.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/side_buffer.sv
// Side buffer for deflected flits with reinjection and stall-driven slot redirection.
// Capture visible on reinj_vld 1 cycle later; captures while full without a pop are dropped.
module side_buffer
  import minbd_pkg::*;
#(
  parameter int FLIT_W   = FLIT_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int REDIR_TH = REDIR_TH_DEF
) (
  input logic         clk,
  input logic         rst_n,
  side_buffer_if.slave sb
);

  localparam int SW = $clog2(REDIR_TH + 1);

  logic              vld;
  logic              full;
  logic              pop;
  logic              drop;
  logic [FLIT_W-1:0] rd_dat;
  logic [SW-1:0]     stall;
  logic [SW-1:0]     stall_nxt;
  logic              ovf;
  redir_state_t      state;

  sb_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (sb.cap_vld),
    .wr_dat (sb.cap_flit),
    .rd_rdy (sb.reinj_ready),
    .rd_vld (vld),
    .rd_dat (rd_dat),
    .full   (full),
    .pop    (pop),
    .drop   (drop)
  );

  // A held head that does not pop is by construction a stalled cycle.
  always_comb begin
    stall_nxt = stall;
    if (pop || !vld) begin
      stall_nxt = '0;
    end else if (stall != SW'(REDIR_TH)) begin
      stall_nxt = stall + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall <= '0;
      ovf   <= 1'b0;
      state <= IDLE;
    end else begin
      stall <= stall_nxt;
      if (drop) ovf <= 1'b1;
      case (state)
        IDLE:     if (stall_nxt == SW'(REDIR_TH)) state <= REDIRECT;
        REDIRECT: if (pop || !vld) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign sb.reinj_vld  = vld;
  assign sb.reinj_flit = rd_dat;
  assign sb.buf_full   = full;
  assign sb.redir_req  = (state == REDIRECT);
  assign sb.ovf_err    = ovf;

endmodule

// File: doc/side_buffer.md
SIDE_BUFFER -- requirements
Module: side_buffer

Interface
REQ-001 SHALL have parameter FLIT_W, default 64, meaning the flit payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the buffer capacity in flits; power of two, at least 2.
REQ-003 SHALL have parameter REDIR_TH, default 8, meaning the number of consecutive stalled cycles before redirection is requested; at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port cap_vld, input, 1 bit: a deflected flit is presented for buffering this cycle.
REQ-007 SHALL have port cap_flit, input, FLIT_W bits: the payload of the deflected flit.
REQ-008 SHALL have port reinj_ready, input, 1 bit: the router has a free input slot this cycle for reinjection.
REQ-009 SHALL have port reinj_vld, output, 1 bit: the buffer head is valid.
REQ-010 SHALL have port reinj_flit, output, FLIT_W bits: the buffer head payload.
REQ-011 SHALL have port buf_full, output, 1 bit: occupancy equals DEPTH.
REQ-012 SHALL have port redir_req, output, 1 bit: request the router to force a free slot.
REQ-013 SHALL have port ovf_err, output, 1 bit: sticky flag set when a capture is lost.

Function
REQ-014 SHALL store flits in a circular FIFO with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, and an occupancy count of clog2(DEPTH+1) bits.
REQ-015 SHALL perform a pop when reinj_vld and reinj_ready are both high; reinj_flit SHALL then advance to the next entry on the following cycle.
REQ-016 SHALL perform a push when cap_vld is high and either count < DEPTH or a pop occurs in the same cycle.
REQ-017 SHALL handle simultaneous push and pop by leaving count unchanged and advancing both pointers; this includes the full case.
REQ-018 SHALL, on cap_vld while full with no pop in the same cycle, drop the flit, leave state unchanged, and set ovf_err, which holds until reset.
REQ-019 SHALL have a push-to-reinj_vld latency of exactly 1 cycle; there is no combinational bypass from cap to reinj.
REQ-020 SHALL drive reinj_vld = (count != 0) and reinj_flit = entry at the read pointer; reinj_flit is don't-care when reinj_vld is low.
REQ-021 SHALL drive buf_full combinationally from the registered count.
REQ-022 SHALL implement a stall counter, saturating at REDIR_TH:
  - increments each cycle reinj_vld=1 and reinj_ready=0;
  - clears on any pop or when the buffer is empty.
REQ-023 SHALL implement a 2-state FSM with states IDLE and REDIRECT:
  - IDLE -> REDIRECT when the stall counter reaches REDIR_TH;
  - REDIRECT -> IDLE on a pop or on the buffer becoming empty;
  - redir_req = (state == REDIRECT).
REQ-024 SHALL drive redir_req from a register, never combinationally from inputs.

Reset
REQ-025 SHALL, while rst_n is low at a clock edge, clear pointers, count, stall counter and ovf_err, set the FSM to IDLE, and drive reinj_vld=0, buf_full=0, redir_req=0.
REQ-026 SHALL NOT reset storage contents.
REQ-027 SHALL, on reset asserted mid-operation, discard all buffered flits and ignore any cap_vld in that cycle.

Structure
REQ-028 SHALL use the shared minbd package for the flit typedef and the DEPTH/REDIR_TH defaults.
REQ-029 SHALL contain one sub-module, sb_fifo, holding storage, pointers and count; the stall counter and FSM sit in side_buffer.

Verification
REQ-030 SHALL cover, with DEPTH=4: push A, B, C with reinj_ready=0, then ready=1 -> reinj_flit A, B, C on successive cycles, then reinj_vld=0.
REQ-031 SHALL cover filling with 4 flits -> buf_full=1; a 5th cap_vld with no pop -> flit dropped and ovf_err=1 permanently.
REQ-032 SHALL cover, when full: cap_vld and reinj_ready in the same cycle -> count stays 4, new flit at tail, FIFO order preserved across pointer wrap.
REQ-033 SHALL cover, with REDIR_TH=8: one flit held with reinj_ready=0 -> redir_req rises after the 8th stalled cycle; one pop -> redir_req=0 the next cycle.
REQ-034 SHALL cover rst_n low for 1 cycle with 3 flits held -> next cycle reinj_vld=0, buf_full=0, redir_req=0, ovf_err=0.
REQ-035 SHALL cover push into an empty buffer with reinj_ready=1 -> reinj_vld rises exactly 1 cycle later, and the flit pops on that cycle.
